// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write bundle for the program loader.
// The master drives start and the byte stream; the slave is the loader itself.
interface inst_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  core_rst;
  logic                  done;
  logic                  err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction-memory program loader: 4-byte little-endian word count, then payload
// bytes packed into 32-bit LE words; holds the core in reset until the last word lands.
module inst_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  inst_mem_loader_if.slave bus
);
  localparam int unsigned IDX_W = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [1:0]            r_byte_cnt;
  logic [IDX_W-1:0]      r_word_idx;
  logic [IDX_W-1:0]      r_len;
  logic [23:0]           r_asm;

  logic                  r_in_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_core_rst;
  logic                  r_done;
  logic                  r_err;

  logic                  w_in_ready_nxt;
  logic                  w_core_rst_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;

  logic                  w_accept;
  logic                  w_byte3;
  logic                  w_restart;
  logic                  w_last_word;
  logic [31:0]           w_full_word;
  logic [IDX_W-1:0]      w_len_m1;

  // r_in_ready mirrors "state is LEN or LOAD", so acceptance never depends on stale state
  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_byte3     = (r_byte_cnt == 2'd3);
  assign w_restart   = bus.start &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_full_word = {bus.in_data, r_asm};
  assign w_len_m1    = r_len - IDX_W'(1);
  assign w_last_word = (r_word_idx == w_len_m1);

  // Next-state and next registered-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_in_ready_nxt = 1'b0;
    w_core_rst_nxt = 1'b1;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_accept && w_byte3) begin
          if (w_full_word == 32'd0)      w_state_nxt = S_DONE;
          else if (w_full_word > DEPTH)  w_state_nxt = S_ERR;
          else                           w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && w_byte3 && w_last_word) w_state_nxt = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (bus.start) w_state_nxt = S_LEN;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_in_ready_nxt = (w_state_nxt == S_LEN) || (w_state_nxt == S_LOAD);
    w_core_rst_nxt = (w_state_nxt != S_DONE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_err_nxt      = (w_state_nxt == S_ERR);
  end

  // State and state-derived status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Byte assembly, length capture and the one-cycle memory write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt  <= 2'd0;
      r_word_idx  <= '0;
      r_len       <= '0;
      r_asm       <= 24'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_restart) begin
        r_byte_cnt <= 2'd0;
        r_word_idx <= '0;
        r_asm      <= 24'd0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_asm[7:0]   <= bus.in_data;
          2'd1:    r_asm[15:8]  <= bus.in_data;
          2'd2:    r_asm[23:16] <= bus.in_data;
          default: r_asm        <= 24'd0;
        endcase
        if (w_byte3) begin
          if (r_state == S_LEN) begin
            // Only consulted in LOAD, where the count is known to fit IDX_W bits
            r_len <= w_full_word[IDX_W-1:0];
          end else begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
            r_mem_wdata <= w_full_word;
            r_word_idx  <= r_word_idx + IDX_W'(1);
          end
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.core_rst  = r_core_rst;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table of load scenarios checked against a stream-level
// model of the expected memory writes, plus hand-written reset and restart sequences.
module tb_inst_mem_loader;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_mem_loader_if #(.ADDR_WIDTH(AW)) bus ();
  inst_mem_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
    logic        done;
    logic        core_rst;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gaps;
    int          mid_start;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  wr_t  wr_q[$];
  int   acc_q[$];
  vec_t vecs[8];

  // Every observed write, with the cycle it appeared and the status seen alongside it
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1)
      wr_q.push_back('{int'(bus.mem_addr), bus.mem_wdata, cyc, bus.done, bus.core_rst});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Present one byte, wait (bounded) for acceptance, log the cycle after it was taken
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: byte 0x%02h never accepted", b);
      bus.in_valid = 1'b0;
    end else begin
      @(negedge clk);
      acc_q.push_back(cyc);
      bus.in_valid = 1'b0;
    end
  endtask

  // Build the stream, drive it, and compare the DUT against the stream-level expectation
  task automatic run_vec(input vec_t v);
    logic [7:0]  bytes[$];
    logic [31:0] pay[$];
    int          npay;
    bit          is_last;
    npay = (v.len <= 32'(DEPTH)) ? int'(v.len) : 0;
    for (int i = 0; i < npay; i++)
      pay.push_back(i == 0 ? v.w0 : (i == 1 ? v.w1 : 32'($urandom())));
    for (int k = 0; k < 4; k++) bytes.push_back(8'(v.len >> (8 * k)));
    foreach (pay[i])
      for (int k = 0; k < 4; k++) bytes.push_back(8'(pay[i] >> (8 * k)));

    wr_q.delete();
    acc_q.delete();
    pulse_start();
    chk({v.name, "_start_ready"}, 32'(bus.in_ready), 32'd1);
    chk({v.name, "_start_corerst"}, 32'(bus.core_rst), 32'd1);
    chk({v.name, "_start_done"}, 32'(bus.done), 32'd0);
    chk({v.name, "_start_err"}, 32'(bus.err), 32'd0);

    foreach (bytes[i]) begin
      send_byte(bytes[i], v.gaps);
      if (i == v.mid_start) pulse_start();
    end

    repeat (3) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;

    chk({v.name, "_nwrites"}, 32'(wr_q.size()), 32'(npay));
    for (int i = 0; i < npay && i < wr_q.size(); i++) begin
      is_last = (i == npay - 1);
      chk({v.name, "_addr"}, 32'(wr_q[i].addr), 32'(i));
      chk({v.name, "_data"}, wr_q[i].data, pay[i]);
      chk({v.name, "_wcycle"}, 32'(wr_q[i].cyc), 32'(acc_q[4 * i + 7]));
      chk({v.name, "_wdone"}, 32'(wr_q[i].done), 32'(is_last));
      chk({v.name, "_wcorerst"}, 32'(wr_q[i].core_rst), 32'(!is_last));
    end
    chk({v.name, "_done"}, 32'(bus.done), 32'(v.exp_done));
    chk({v.name, "_err"}, 32'(bus.err), 32'(v.exp_err));
    chk({v.name, "_corerst"}, 32'(bus.core_rst), 32'(!v.exp_done));
    chk({v.name, "_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_core_rst"}, 32'(bus.core_rst), 32'd1);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   rlen;
    rlen = int'($urandom_range(3, 40));
    vecs[0] = '{"two_words",     32'd2,   32'h00000113, 32'h00100193, 1'b0, -1, 1'b1, 1'b0};
    vecs[1] = '{"zero_len",      32'd0,   32'h0,        32'h0,        1'b0, -1, 1'b1, 1'b0};
    vecs[2] = '{"too_long",      32'd257, 32'h0,        32'h0,        1'b0, -1, 1'b0, 1'b1};
    vecs[3] = '{"after_err",     32'd1,   32'h12345678, 32'h0,        1'b0, -1, 1'b1, 1'b0};
    vecs[4] = '{"gappy",         32'd2,   32'h00000113, 32'h00100193, 1'b1, -1, 1'b1, 1'b0};
    vecs[5] = '{"start_in_load", 32'd2,   32'hA5A55A5A, 32'h0F1E2D3C, 1'b0,  5, 1'b1, 1'b0};
    vecs[6] = '{"full_depth",    32'(DEPTH), 32'($urandom()), 32'($urandom()), 1'b0, -1, 1'b1, 1'b0};
    vecs[7] = '{"random_len",    32'(rlen), 32'($urandom()), 32'($urandom()), 1'b1, -1, 1'b1, 1'b0};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    // Bytes offered in IDLE must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle_ready", 32'(bus.in_ready), 32'd0);
    chk("idle_nwrites", 32'(wr_q.size()), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-word: header len=2, then two payload bytes, then async reset
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    v = '{"after_reset", 32'd1, 32'hCAFEF00D, 32'h0, 1'b0, -1, 1'b1, 1'b0};
    run_vec(v);

    // Restart from DONE
    v = '{"deadbeef", 32'd1, 32'hDEADBEEF, 32'h0, 1'b0, -1, 1'b1, 1'b0};
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
